pattern_renderer: RTL and testbench

//   Parametrised, pipelined test-pattern generator for the VGA path. Generalises the quadrant renderer.

---
 rtl/pattern_pkg.sv | 52 +++++
 rtl/pattern_renderer_box_mover.sv | 56 +++++
 rtl/pattern_renderer.sv | 171 +++++++++++++++++
 tb/tb_pattern_renderer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// ---------------------------------------------------------------------------
// pattern_pkg
//   Shared definitions for the VGA test-pattern renderer.
//   - mode_t       : pattern mode codes as seen on the 2-bit mode input
//   - rgb_code_t   : 3-bit on/off colour code, bit 2 = red, 1 = green, 0 = blue
//   - bar_code()   : the 8-entry colour-bar table
//   - expand_channel() : widens one on/off bit to a full channel value
// ---------------------------------------------------------------------------
package pattern_pkg;

   typedef enum logic [1:0] {
      MODE_QUAD  = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_BOX   = 2'd3
   } mode_t;

   typedef logic [2:0] rgb_code_t;

   localparam rgb_code_t RGB_BLACK   = 3'b000;
   localparam rgb_code_t RGB_BLUE    = 3'b001;
   localparam rgb_code_t RGB_GREEN   = 3'b010;
   localparam rgb_code_t RGB_CYAN    = 3'b011;
   localparam rgb_code_t RGB_RED     = 3'b100;
   localparam rgb_code_t RGB_MAGENTA = 3'b101;
   localparam rgb_code_t RGB_YELLOW  = 3'b110;
   localparam rgb_code_t RGB_WHITE   = 3'b111;

   // Widest channel that expand_channel() can serve; callers size-cast down.
   localparam int MAX_CW = 16;

   // Classic colour-bar order, left to right.
   function automatic rgb_code_t bar_code(input logic [2:0] k);
      rgb_code_t c;
      case (k)
         3'd0:    c = RGB_WHITE;
         3'd1:    c = RGB_YELLOW;
         3'd2:    c = RGB_CYAN;
         3'd3:    c = RGB_GREEN;
         3'd4:    c = RGB_MAGENTA;
         3'd5:    c = RGB_RED;
         3'd6:    c = RGB_BLUE;
         default: c = RGB_BLACK;
      endcase
      return c;
   endfunction

   function automatic logic [MAX_CW-1:0] expand_channel(input logic on);
      return on ? '1 : '0;
   endfunction

endpackage

// File: rtl/pattern_renderer_box_mover.sv
// ---------------------------------------------------------------------------
// box_mover
//   One axis of the bouncing box. On each step_en pulse the position moves
//   STEP towards the current direction, clamping at 0 and LIMIT and
//   reversing there, so it never leaves [0, LIMIT] and never wraps.
// Ports
//   clk      in   1  pixel clock
//   rst_n    in   1  synchronous reset, active low (pos=0, moving up)
//   step_en  in   1  advance one step (frame_start)
//   pos      out  W  current box coordinate on this axis
// ---------------------------------------------------------------------------
module box_mover #(
   parameter int W     = 11,
   parameter int LIMIT = 608,
   parameter int STEP  = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         step_en,
   output logic [W-1:0] pos
);

   localparam logic [W:0]   LIMIT_X = (W+1)'(LIMIT);
   localparam logic [W:0]   STEP_X  = (W+1)'(STEP);
   localparam logic [W-1:0] LIMIT_W = W'(LIMIT);
   localparam logic [W-1:0] STEP_W  = W'(STEP);

   logic         moving_down;   // 0: position increasing, 1: decreasing
   logic [W:0]   nxt_up;        // one bit wider so the overshoot test cannot wrap

   assign nxt_up = {1'b0, pos} + STEP_X;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos         <= '0;
         moving_down <= 1'b0;
      end else if (step_en) begin
         if (!moving_down) begin
            if (nxt_up > LIMIT_X) begin
               pos         <= LIMIT_W;
               moving_down <= 1'b1;
            end else begin
               pos <= nxt_up[W-1:0];
            end
         end else begin
            if (pos < STEP_W) begin
               pos         <= '0;
               moving_down <= 1'b0;
            end else begin
               pos <= pos - STEP_W;
            end
         end
      end
   end

endmodule

// File: rtl/pattern_renderer.sv
// ---------------------------------------------------------------------------
// pattern_renderer
//   Two-stage pipelined VGA test-pattern generator. Maps a pixel coordinate
//   from the timing generator to an RGB colour in one of four modes:
//   quadrants, colour bars, checkerboard, bouncing box.
//
//   Stream protocol: valid-only, no back-pressure. A pixel is taken on every
//   rising edge where in_valid=1 and its colour is presented two cycles
//   later with out_valid=1; out_valid is in_valid delayed by two cycles and
//   r/g/b are zero whenever out_valid is 0.
//
// Ports
//   clk          in   1     pixel clock
//   rst_n        in   1     synchronous reset, active low; flushes pipeline
//   x, y         in   XY_W  pixel column / row
//   in_valid     in   1     x/y carry a pixel this cycle
//   frame_start  in   1     once-per-frame pulse: latches mode, moves box
//   mode         in   2     0 quad, 1 bars, 2 checker, 3 box
//   r, g, b      out  CW    colour channels (registered)
//   out_valid    out  1     r/g/b valid
// ---------------------------------------------------------------------------
module pattern_renderer
   import pattern_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int XY_W       = 11,
   parameter int CW         = 3,
   parameter int CHECK_LOG2 = 5,
   parameter int BOX_SIZE   = 32,
   parameter int BOX_STEP   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XY_W-1:0] x,
   input  logic [XY_W-1:0] y,
   input  logic            in_valid,
   input  logic            frame_start,
   input  logic [1:0]      mode,
   output logic [CW-1:0]   r,
   output logic [CW-1:0]   g,
   output logic [CW-1:0]   b,
   output logic            out_valid
);

   localparam int BW = H_ACTIVE / 8;

   localparam logic [XY_W-1:0] H_LIM    = XY_W'(H_ACTIVE);
   localparam logic [XY_W-1:0] V_LIM    = XY_W'(V_ACTIVE);
   localparam logic [XY_W-1:0] H_HALF   = XY_W'(H_ACTIVE / 2);
   localparam logic [XY_W-1:0] V_HALF   = XY_W'(V_ACTIVE / 2);
   localparam logic [XY_W-1:0] BARS_END = XY_W'(8 * BW);
   localparam logic [XY_W:0]   BOX_X    = (XY_W+1)'(BOX_SIZE);
   localparam logic [CW-1:0]   HALF     = CW'(1) << (CW - 1);

   // ---------------- frame-level state ----------------
   mode_t           active_mode;
   logic [XY_W-1:0] bx, by;

   // Mode changes only at frame boundaries so a frame is never split.
   always_ff @(posedge clk) begin
      if (!rst_n)           active_mode <= MODE_QUAD;
      else if (frame_start) active_mode <= mode_t'(mode);
   end

   box_mover #(.W(XY_W), .LIMIT(H_ACTIVE - BOX_SIZE), .STEP(BOX_STEP)) u_box_x (
      .clk(clk), .rst_n(rst_n), .step_en(frame_start), .pos(bx)
   );
   box_mover #(.W(XY_W), .LIMIT(V_ACTIVE - BOX_SIZE), .STEP(BOX_STEP)) u_box_y (
      .clk(clk), .rst_n(rst_n), .step_en(frame_start), .pos(by)
   );

   // ---------------- stage 1: region flags ----------------
   logic [2:0] bar_k;
   logic [XY_W:0] bx_end, by_end;
   logic in_box;

   // Comparator chain instead of a divide: the last threshold passed wins.
   always_comb begin
      bar_k = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (x >= XY_W'(i * BW)) bar_k = 3'(i);
      end
   end

   // Box end computed one bit wider so bx+BOX_SIZE cannot wrap.
   assign bx_end = {1'b0, bx} + BOX_X;
   assign by_end = {1'b0, by} + BOX_X;
   assign in_box = (x >= bx) && ({1'b0, x} < bx_end) &&
                   (y >= by) && ({1'b0, y} < by_end);

   logic       s1_valid, s1_in_range, s1_left, s1_top;
   logic       s1_bar_beyond, s1_check, s1_box;
   logic [2:0] s1_bar;
   mode_t      s1_mode;

   // Mode travels with the pixel: a frame_start in the same cycle as a
   // pixel must not recolour that pixel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid      <= 1'b0;
         s1_in_range   <= 1'b0;
         s1_left       <= 1'b0;
         s1_top        <= 1'b0;
         s1_bar_beyond <= 1'b0;
         s1_check      <= 1'b0;
         s1_box        <= 1'b0;
         s1_bar        <= 3'd0;
         s1_mode       <= MODE_QUAD;
      end else begin
         s1_valid      <= in_valid;
         s1_in_range   <= (x < H_LIM) && (y < V_LIM);
         s1_left       <= x < H_HALF;
         s1_top        <= y < V_HALF;
         s1_bar_beyond <= x >= BARS_END;
         s1_check      <= x[CHECK_LOG2] ^ y[CHECK_LOG2];
         s1_box        <= in_box;
         s1_bar        <= bar_k;
         s1_mode       <= active_mode;
      end
   end

   // ---------------- stage 2: colour select ----------------
   rgb_code_t code;
   logic      grey;

   always_comb begin
      code = RGB_BLACK;
      grey = 1'b0;
      case (s1_mode)
         MODE_QUAD: begin
            if (s1_left && s1_top) code = RGB_RED;
            else if (s1_left)      code = RGB_GREEN;
            else if (s1_top)       code = RGB_BLUE;
            else                   grey = 1'b1;
         end
         MODE_BARS:  code = s1_bar_beyond ? RGB_BLACK : bar_code(s1_bar);
         MODE_CHECK: code = s1_check ? RGB_WHITE : RGB_BLACK;
         default:    code = s1_box ? RGB_WHITE : RGB_BLACK;
      endcase
      if (!s1_in_range) begin
         code = RGB_BLACK;
         grey = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r         <= '0;
         g         <= '0;
         b         <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= s1_valid;
         if (!s1_valid) begin
            r <= '0;
            g <= '0;
            b <= '0;
         end else if (grey) begin
            r <= HALF;
            g <= HALF;
            b <= HALF;
         end else begin
            r <= CW'(expand_channel(code[2]));
            g <= CW'(expand_channel(code[1]));
            b <= CW'(expand_channel(code[0]));
         end
      end
   end

endmodule

// File: tb/tb_pattern_renderer.sv
// ---------------------------------------------------------------------------
// tb_pattern_renderer
//   Scoreboard bench for pattern_renderer (defaults, CW=3). A sampling
//   process mirrors what the DUT sees at each rising edge, computes the
//   expected colour from a coordinate-level reference model and queues it
//   with the sample cycle; a monitor on the falling edge pops one entry per
//   out_valid and checks colour and two-cycle latency.
// ---------------------------------------------------------------------------
module tb_pattern_renderer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] x, y;
   logic        in_valid, frame_start;
   logic [1:0]  mode;
   logic [2:0]  r, g, b;
   logic        out_valid;

   pattern_renderer dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .in_valid(in_valid),
      .frame_start(frame_start), .mode(mode), .r(r), .g(g), .b(b),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   localparam logic [8:0] BARS [8] = '{9'o777, 9'o770, 9'o077, 9'o070,
                                       9'o707, 9'o700, 9'o007, 9'o000};
   int m_mode, m_bx, m_by;
   bit m_dx_up, m_dy_up;

   function automatic logic [8:0] ref_rgb(input int px, input int py, input int md,
                                          input int bxp, input int byp);
      if (px >= 640 || py >= 480) return 9'o000;
      case (md)
         0: begin
            if (px < 320) return (py < 240) ? 9'o700 : 9'o070;
            else          return (py < 240) ? 9'o007 : 9'o444;
         end
         1: return BARS[px / 80];
         2: return (((px / 32) + (py / 32)) % 2 == 1) ? 9'o777 : 9'o000;
         default:
            return (px >= bxp && px < bxp + 32 && py >= byp && py < byp + 32) ? 9'o777 : 9'o000;
      endcase
   endfunction

   function automatic void axis_step(input int p, input bit up, input int lim,
                                     output int np, output bit nup);
      np = p; nup = up;
      if (up) begin
         if (p + 2 > lim) begin np = lim; nup = 1'b0; end
         else np = p + 2;
      end else begin
         if (p < 2) begin np = 0; nup = 1'b1; end
         else np = p - 2;
      end
   endfunction

   // ---------------- scoreboard ----------------
   logic [8:0] exp_q[$];
   int         exp_t[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         quiet_left = 0;
   string      phase = "reset";

   always @(posedge clk) begin
      int nbx, nby;
      bit ndx, ndy;
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         exp_t.delete();
         m_mode = 0; m_bx = 0; m_by = 0; m_dx_up = 1'b1; m_dy_up = 1'b1;
      end else begin
         if (in_valid) begin
            exp_q.push_back(ref_rgb(int'(x), int'(y), m_mode, m_bx, m_by));
            exp_t.push_back(cyc);
         end
         if (frame_start) begin
            m_mode = int'(mode);
            axis_step(m_bx, m_dx_up, 608, nbx, ndx);
            axis_step(m_by, m_dy_up, 448, nby, ndy);
            m_bx = nbx; m_dx_up = ndx; m_by = nby; m_dy_up = ndy;
         end
      end
   end

   always @(negedge clk) begin
      logic [8:0] e;
      int t;
      if (quiet_left > 0) begin
         checks++;
         if (out_valid !== 1'b0 || {r, g, b} !== 9'o000) begin
            errors++;
            $display("FAIL %s.quiet: got valid=%b rgb=%o exp valid=0 rgb=000",
                     phase, out_valid, {r, g, b});
         end
         quiet_left--;
      end
      if (out_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s.unexpected_valid: got out_valid=1 rgb=%o exp no output",
                     phase, {r, g, b});
         end else begin
            e = exp_q.pop_front();
            t = exp_t.pop_front();
            if ({r, g, b} !== e || cyc != t + 1) begin
               errors++;
               $display("FAIL %s.pixel: got rgb=%o at cycle %0d exp rgb=%o at cycle %0d",
                        phase, {r, g, b}, cyc, e, t + 1);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input int px, input int py, input bit v, input bit fs, input int m);
      x           = px[10:0];
      y           = py[10:0];
      in_valid    = v;
      frame_start = fs;
      mode        = m[1:0];
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, int'(mode));
   endtask

   initial begin
      rst_n = 1'b0; x = '0; y = '0; in_valid = 1'b0; frame_start = 1'b0; mode = 2'd0;
      @(posedge clk); #1;
      quiet_left = 2;
      idle(2);
      rst_n = 1'b1;

      // 1. reset mid-stream (with a frame_start that must lose to reset)
      phase = "mid_reset";
      for (int i = 0; i < 4; i++) drive(i * 100, 10, 1'b1, 1'b0, 0);
      rst_n = 1'b0;
      drive(400, 10, 1'b1, 1'b1, 3);
      drive(500, 10, 1'b1, 1'b1, 3);
      rst_n = 1'b1;
      quiet_left = 2;
      for (int i = 0; i < 4; i++) drive(i * 200, 300, 1'b1, 1'b0, 3);
      idle(3);

      // 2. quadrants
      phase = "quad";
      drive(0, 0, 1'b1, 1'b0, 0);
      drive(639, 0, 1'b1, 1'b0, 0);
      drive(0, 479, 1'b1, 1'b0, 0);
      drive(639, 479, 1'b1, 1'b0, 0);
      drive(700, 10, 1'b1, 1'b0, 0);
      idle(3);

      // 3. bars then checker
      phase = "bars";
      drive(0, 0, 1'b0, 1'b1, 1);
      drive(79, 5, 1'b1, 1'b0, 1);
      drive(80, 5, 1'b1, 1'b0, 1);
      drive(560, 5, 1'b1, 1'b0, 1);
      drive(639, 5, 1'b1, 1'b0, 1);
      phase = "checker";
      drive(0, 0, 1'b0, 1'b1, 2);
      drive(31, 0, 1'b1, 1'b0, 2);
      drive(32, 0, 1'b1, 1'b0, 2);
      drive(32, 32, 1'b1, 1'b0, 2);
      idle(3);

      // 4. mode change mid-frame only takes effect at frame_start
      phase = "mode_latch";
      drive(0, 0, 1'b0, 1'b1, 0);
      drive(0, 0, 1'b1, 1'b0, 2);
      drive(639, 479, 1'b1, 1'b0, 2);
      drive(0, 0, 1'b1, 1'b1, 2);   // same-cycle pixel still quadrant
      drive(0, 0, 1'b1, 1'b0, 0);
      drive(32, 0, 1'b1, 1'b0, 0);
      idle(3);

      // 6. bubbles: 1,0,1,1
      phase = "bubbles";
      drive(10, 10, 1'b1, 1'b0, 0);
      drive(20, 10, 1'b0, 1'b0, 0);
      drive(30, 10, 1'b1, 1'b0, 0);
      drive(40, 10, 1'b1, 1'b0, 0);
      idle(3);

      // 5. bouncing box over 400 frames, probing its edges
      phase = "box";
      rst_n = 1'b0; idle(1); rst_n = 1'b1;
      drive(0, 0, 1'b0, 1'b0, 3);
      for (int f = 0; f < 400; f++) begin
         drive(m_bx, m_by, (f % 7) == 0, 1'b1, 3);
         drive(m_bx, m_by, 1'b1, 1'b0, 3);
         drive(m_bx + 31, m_by + 31, 1'b1, 1'b0, 3);
         drive(m_bx + 32, m_by, 1'b1, 1'b0, 3);
         drive(m_bx, m_by + 32, 1'b1, 1'b0, 3);
         if (m_bx > 0) drive(m_bx - 1, m_by, 1'b1, 1'b0, 3);
         if (m_by > 0) drive(m_bx, m_by - 1, 1'b1, 1'b0, 3);
      end
      idle(3);

      // random frames, random bubbles, mode input wiggling mid-frame
      phase = "random";
      for (int f = 0; f < 20; f++) begin
         drive($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 1) == 1,
               1'b1, $urandom_range(0, 3));
         for (int p = 0; p < 40; p++) begin
            drive($urandom_range(0, 700), $urandom_range(0, 520),
                  $urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 3));
         end
      end
      idle(5);

      phase = "drain";
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pixels never output exp 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
